// File: rtl/qam16_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : qam16_rx_pkg
// Description : Shared constants, types and phase-step helper for the QAM16 RX decimator.
// Revision    : 1.0
// ============================================================================
package qam16_rx_pkg;

    localparam int OSR         = 8;
    localparam int PHASE_W     = 3;
    localparam int DS_DW       = 12;
    localparam int DS_WIN_LOG2 = 5;

    localparam int METRIC_W = DS_DW + 1;
    localparam int ACC_W    = DS_DW + 1 + DS_WIN_LOG2;

    typedef logic [PHASE_W-1:0]  phase_t;
    typedef logic [METRIC_W-1:0] metric_t;
    typedef logic [ACC_W-1:0]    acc_t;

    // One step toward tgt along the shorter circular path; a half-turn goes forward.
    function automatic phase_t phase_step(input phase_t cur, input phase_t tgt);
        phase_t d;
        d = tgt - cur;
        if (d == '0)
            return cur;
        else if (d <= phase_t'(OSR / 2))
            return cur + phase_t'(1);
        else
            return cur - phase_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/downsample_sync_energy.sv
`default_nettype none
// ============================================================================
// Module      : ds_phase_energy
// Description : Eight per-phase energy accumulators with argmax (ties to lowest phase).
// Revision    : 1.0
// ============================================================================
module ds_phase_energy
    import qam16_rx_pkg::*;
#(
    parameter int DW       = DS_DW,
    parameter int WIN_LOG2 = DS_WIN_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          add,
    input  logic [2:0]    phase,
    input  logic [DW:0]   metric,
    output logic [2:0]    best
);

    localparam int AW = DW + 1 + WIN_LOG2;

    logic [AW-1:0] r_acc [OSR];
    logic [AW-1:0] w_sum [OSR];
    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_best_val;

    // The argmax sees the sample being added this cycle, so the closing sample
    // of a window counts and the caller can register the result at that edge.
    always_comb begin
        w_inc      = AW'(metric);
        w_best_val = '0;
        best       = '0;
        for (int p = 0; p < OSR; p++) begin
            w_sum[p] = r_acc[p] + ((add && (phase == phase_t'(p))) ? w_inc : '0);
        end
        w_best_val = w_sum[0];
        for (int p = 1; p < OSR; p++) begin
            if (w_sum[p] > w_best_val) begin
                w_best_val = w_sum[p];
                best       = phase_t'(p);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < OSR; p++) r_acc[p] <= '0;
        end else if (clear) begin
            for (int p = 0; p < OSR; p++) r_acc[p] <= '0;
        end else if (add) begin
            r_acc[phase] <= w_sum[phase];
        end
    end

endmodule
`default_nettype wire

// File: rtl/downsample_sync.sv
`default_nettype none
// ============================================================================
// Module      : downsample_sync
// Description : 8x RX decimator choosing the highest-energy sampling phase.
//               DS_PHASE_TRACK_EN enables one-step phase tracking after lock.
// Revision    : 1.0
// ============================================================================
module downsample_sync
    import qam16_rx_pkg::*;
#(
    parameter int         DW         = DS_DW,
    parameter int         WIN_LOG2   = DS_WIN_LOG2,
    parameter logic [2:0] PHASE_INIT = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_vld,
    input  logic signed [DW-1:0] I,
    input  logic signed [DW-1:0] Q,
    output logic signed [DW-1:0] DOWN_I,
    output logic signed [DW-1:0] DOWN_Q,
    output logic                 dout_vld,
    output logic [2:0]           phase_sel,
    output logic                 locked
);

    localparam logic [WIN_LOG2-1:0] c_sym_one = 1;

    logic [2:0]          r_ph_cnt;
    logic [WIN_LOG2-1:0] r_sym_cnt;

    logic signed [DW:0]  w_ext_i;
    logic signed [DW:0]  w_ext_q;
    logic [DW:0]         w_abs_i;
    logic [DW:0]         w_abs_q;
    logic [DW:0]         w_metric;
    logic                w_win_end;
    logic                w_take;
    logic                w_add;
    logic                w_clear;
    logic [2:0]          w_best;
    logic [2:0]          w_phase_next;

    // One extra bit makes |-2^(DW-1)| exact.
    always_comb begin
        w_ext_i  = {I[DW-1], I};
        w_ext_q  = {Q[DW-1], Q};
        w_abs_i  = w_ext_i[DW] ? $unsigned(-w_ext_i) : $unsigned(w_ext_i);
        w_abs_q  = w_ext_q[DW] ? $unsigned(-w_ext_q) : $unsigned(w_ext_q);
        w_metric = w_abs_i + w_abs_q;
    end

    always_comb begin
        w_win_end = din_vld && (r_ph_cnt == 3'd7) && (r_sym_cnt == '1);
        w_take    = din_vld && (r_ph_cnt == phase_sel);
`ifdef DS_PHASE_TRACK_EN
        w_add        = din_vld;
        w_clear      = w_win_end;
        w_phase_next = locked ? phase_step(phase_sel, w_best) : w_best;
`else
        // Frozen after first lock: energy measurement is no longer needed.
        w_add        = din_vld && !locked;
        w_clear      = w_win_end && !locked;
        w_phase_next = w_best;
`endif
    end

    ds_phase_energy #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_energy (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .add    (w_add),
        .phase  (r_ph_cnt),
        .metric (w_metric),
        .best   (w_best)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph_cnt  <= '0;
            r_sym_cnt <= '0;
        end else if (din_vld) begin
            r_ph_cnt <= r_ph_cnt + 3'd1;
            if (r_ph_cnt == 3'd7)
                r_sym_cnt <= r_sym_cnt + c_sym_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DOWN_I   <= '0;
            DOWN_Q   <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= w_take;
            if (w_take) begin
                DOWN_I <= I;
                DOWN_Q <= Q;
            end
        end
    end

    // The window-end sample itself is still decimated with the old phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_sel <= PHASE_INIT;
            locked    <= 1'b0;
        end else if (w_clear) begin
            phase_sel <= w_phase_next;
            locked    <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_downsample_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_downsample_sync
// Description : Scoreboard bench for downsample_sync (DS_PHASE_TRACK_EN aware).
// Revision    : 1.0
// ============================================================================
module tb_downsample_sync;

    localparam int DW = 12;
`ifdef DS_PHASE_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 din_vld;
    logic signed [DW-1:0] I;
    logic signed [DW-1:0] Q;
    logic signed [DW-1:0] DOWN_I;
    logic signed [DW-1:0] DOWN_Q;
    logic                 dout_vld;
    logic [2:0]           phase_sel;
    logic                 locked;

    always #5 clk = ~clk;

    downsample_sync #(
        .DW         (DW),
        .WIN_LOG2   (5),
        .PHASE_INIT (3'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_vld   (din_vld),
        .I         (I),
        .Q         (Q),
        .DOWN_I    (DOWN_I),
        .DOWN_Q    (DOWN_Q),
        .dout_vld  (dout_vld),
        .phase_sel (phase_sel),
        .locked    (locked)
    );

    int n_checks = 0;
    int n_errors = 0;

    int m_ph, m_sym, m_phase, m_locked, m_last_i, m_last_q;
    int m_acc [8];
    int sb_i [$];
    int sb_q [$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int step_toward(input int cur, input int tgt);
        int d;
        d = (tgt - cur + 8) % 8;
        if (d == 0) return cur;
        if (d <= 4) return (cur + 1) % 8;
        return (cur + 7) % 8;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_sym = 0; m_phase = 0; m_locked = 0;
        m_last_i = 0; m_last_q = 0;
        for (int k = 0; k < 8; k++) m_acc[k] = 0;
        sb_i.delete();
        sb_q.delete();
    endtask

    // One clock: drive a sample (or a gap), update the model, check the result.
    task automatic cyc(input bit v, input int i, input int q);
        bit exp_v;
        int best;
        @(negedge clk);
        check("phase_sel", int'(phase_sel), m_phase);
        check("locked", int'(locked), m_locked);
        din_vld = v;
        I = DW'(i);
        Q = DW'(q);
        exp_v = 1'b0;
        if (v) begin
            if (m_ph == m_phase) begin
                sb_i.push_back(i);
                sb_q.push_back(q);
                exp_v = 1'b1;
            end
            if (TRACK || m_locked == 0) begin
                m_acc[m_ph] += iabs(i) + iabs(q);
                if (m_ph == 7 && m_sym == 31) begin
                    best = 0;
                    for (int k = 1; k < 8; k++) if (m_acc[k] > m_acc[best]) best = k;
                    m_phase  = (TRACK && m_locked != 0) ? step_toward(m_phase, best) : best;
                    m_locked = 1;
                    for (int k = 0; k < 8; k++) m_acc[k] = 0;
                end
            end
            m_ph = (m_ph + 1) % 8;
            if (m_ph == 0) m_sym = (m_sym + 1) % 32;
        end
        @(posedge clk);
        #1;
        check("dout_vld", int'(dout_vld), int'(exp_v));
        if (exp_v) begin
            m_last_i = sb_i.pop_front();
            m_last_q = sb_q.pop_front();
        end
        check("DOWN_I", int'(DOWN_I), m_last_i);
        check("DOWN_Q", int'(DOWN_Q), m_last_q);
    endtask

    task automatic run_win(input int pk1, input int pk2, input int amp,
                           input bit noise, input bit gaps, input int nsym);
        int val, qv;
        for (int s = 0; s < nsym; s++) begin
            for (int p = 0; p < 8; p++) begin
                if (p == pk1 || p == pk2) begin
                    val = amp;
                    qv  = amp;
                end else begin
                    val = noise ? ((s * 3 + p) % 7) - 3 : 0;
                    qv  = -val;
                end
                if (gaps) begin
                    for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++)
                        cyc(1'b0, int'($urandom_range(4095, 0)) - 2048, int'($urandom_range(4095, 0)) - 2048);
                end
                cyc(1'b1, val, qv);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_dout_vld", int'(dout_vld), 0);
        check("rst_DOWN_I", int'(DOWN_I), 0);
        check("rst_DOWN_Q", int'(DOWN_Q), 0);
        check("rst_phase_sel", int'(phase_sel), 0);
        check("rst_locked", int'(locked), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        din_vld = 1'b0;
        I = '0;
        Q = '0;
        model_reset();
        do_reset();

        // Strong pulse at phase 3
        run_win(3, -1, 500, 1'b1, 1'b0, 32);
        check("t2_phase", int'(phase_sel), 3);
        check("t2_locked", int'(locked), 1);
        run_win(3, -1, 500, 1'b1, 1'b0, 4);
        check("t2_down_i", int'(DOWN_I), 500);

        // Equal energy at phases 2 and 5
        do_reset();
        run_win(2, 5, 300, 1'b0, 1'b0, 32);
        check("t3_tie", int'(phase_sel), 2);

        // Full-scale negative input
        do_reset();
        run_win(6, -1, -2048, 1'b0, 1'b0, 32);
        check("t4_extreme", int'(phase_sel), 6);
        run_win(6, -1, -2048, 1'b0, 1'b0, 2);
        check("t4_down_i", int'(DOWN_I), -2048);

        // Random valid gaps
        do_reset();
        run_win(3, -1, 500, 1'b1, 1'b1, 32);
        check("t5_phase", int'(phase_sel), 3);
        run_win(3, -1, 500, 1'b1, 1'b1, 4);

        // Peak moves 3 -> 6
        do_reset();
        run_win(3, -1, 500, 1'b1, 1'b0, 32);
        check("t6_acquire", int'(phase_sel), 3);
        for (int w = 0; w < 3; w++) begin
            run_win(6, -1, 500, 1'b1, 1'b0, 32);
            check("t6_track", int'(phase_sel), TRACK ? 4 + w : 3);
        end

        // Reset mid-window must discard the partial sums
        run_win(5, -1, 1500, 1'b0, 1'b0, 16);
        do_reset();
        run_win(5, -1, 1500, 1'b0, 1'b0, 16);
        do_reset();
        run_win(1, -1, 500, 1'b0, 1'b0, 32);
        check("rst_rearm_phase", int'(phase_sel), 1);
        check("rst_rearm_locked", int'(locked), 1);

        @(negedge clk);
        din_vld = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
